// File: rtl/const_div_pipe_if.sv
// Stream interface for const_div_pipe: a valid/ready input channel carrying
// the signed dividend and a valid/ready output channel carrying quotient and
// remainder. The divider is the slave; whatever drives and consumes it is the
// master.
interface const_div_pipe_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_quot;
  logic signed [WIDTH-1:0] out_rem;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_quot, out_rem
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_quot, out_rem
  );
endinterface

// File: rtl/const_div_pipe.sv
// const_div_pipe: pipelined signed divide-by-constant.
// The quotient is floor(in * RECIP / 2**FRAC), with RECIP = ceil(2**FRAC / DIVISOR).
// Stages: S0 input register, S1 product, S2 floor shift. Defining the macro
// CONST_DIV_PIPE_EXACT_EN adds S3, which corrects the estimate by one step
// to the truncating quotient and produces the remainder.
// A single global enable (!stall) freezes the whole pipeline under backpressure.
module const_div_pipe #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 3,
  parameter int FRAC    = 10
) (
  input  logic           clk,
  input  logic           rst,
  const_div_pipe_if.slave bus
);
  localparam int PW = WIDTH + FRAC + 2;
  localparam logic [PW-1:0] POW     = PW'(1) << FRAC;
  localparam logic [PW-1:0] RECIP_W = (POW + PW'(DIVISOR) - PW'(1)) / PW'(DIVISOR);
  localparam logic [FRAC:0] RECIP   = RECIP_W[FRAC:0];
`ifdef CONST_DIV_PIPE_EXACT_EN
  // Two guard bits let the raw estimate overshoot before correction.
  localparam int QW = WIDTH + 2;
  localparam int RW = 2 * WIDTH + 4;
  localparam logic signed [RW-1:0] D_X = RW'(DIVISOR);
`else
  localparam int QW = WIDTH;
`endif

  if (FRAC < WIDTH + 2) begin : g_frac_check
    $error("const_div_pipe: FRAC must be at least WIDTH+2");
  end

  logic                    stall;
  logic                    v0_q, v1_q, v2_q;
  logic signed [WIDTH-1:0] in0_q;
  logic signed [PW-1:0]    prod_d, p_q;
  logic signed [QW-1:0]    q0_d, q0_q;

  // The output register is the only place backpressure can be seen; when it
  // holds an unaccepted result, every stage freezes together.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // S0: capture the dividend on an input handshake; a bubble clears the valid.
  // NOTE: data registers are reset too, so outputs can never show X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b0;
      in0_q <= '0;
    end else if (!stall) begin
      // NOTE: state is updated with <= so every stage samples pre-edge values.
      v0_q <= bus.in_valid;
      if (bus.in_valid) in0_q <= bus.in_data;
    end
  end

  // Sign-extended dividend times the zero-extended (always positive) reciprocal.
  assign prod_d = $signed({{(PW - WIDTH){in0_q[WIDTH-1]}}, in0_q})
                * $signed({{(PW - FRAC - 1){1'b0}}, RECIP});

  // The arithmetic shift is the floor; bits above QW are never significant.
  assign q0_d = QW'(p_q >>> FRAC);

`ifdef CONST_DIV_PIPE_EXACT_EN
  logic signed [WIDTH-1:0] in1_q, in2_q;
  logic                    v3_q;
  logic signed [WIDTH-1:0] quot_d, quot_q, rem_d, rem_q;
  logic signed [RW-1:0]    r0, qc, rc;
`endif

  // S1: register the product; the exact build also carries the dividend along.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      p_q  <= '0;
`ifdef CONST_DIV_PIPE_EXACT_EN
      in1_q <= '0;
`endif
    end else if (!stall) begin
      v1_q <= v0_q;
      if (v0_q) begin
        p_q <= prod_d;
`ifdef CONST_DIV_PIPE_EXACT_EN
        in1_q <= in0_q;
`endif
      end
    end
  end

  // S2: register the floored quotient estimate.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      q0_q <= '0;
`ifdef CONST_DIV_PIPE_EXACT_EN
      in2_q <= '0;
`endif
    end else if (!stall) begin
      v2_q <= v1_q;
      if (v1_q) begin
        q0_q <= q0_d;
`ifdef CONST_DIV_PIPE_EXACT_EN
        in2_q <= in1_q;
`endif
      end
    end
  end

`ifdef CONST_DIV_PIPE_EXACT_EN
  // Remainder of the estimate, then one step toward the truncating quotient.
  // The estimate is at most one off, so a single correction always suffices.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch forms.
    r0 = RW'(in2_q) - RW'(q0_q) * D_X;
    qc = RW'(q0_q);
    rc = r0;
    if (!in2_q[WIDTH-1]) begin
      if (r0 < 0) begin
        qc = RW'(q0_q) - 1;
        rc = r0 + D_X;
      end else if (r0 >= D_X) begin
        qc = RW'(q0_q) + 1;
        rc = r0 - D_X;
      end
    end else begin
      if (r0 > 0) begin
        qc = RW'(q0_q) + 1;
        rc = r0 - D_X;
      end else if (r0 <= -D_X) begin
        qc = RW'(q0_q) - 1;
        rc = r0 + D_X;
      end
    end
    quot_d = WIDTH'(qc);
    rem_d  = WIDTH'(rc);
  end

  // S3: register the corrected quotient and remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (!stall) begin
      v3_q <= v2_q;
      if (v2_q) begin
        quot_q <= quot_d;
        rem_q  <= rem_d;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_quot  = quot_q;
  assign bus.out_rem   = rem_q;
`else
  assign bus.out_valid = v2_q;
  assign bus.out_quot  = q0_q;
  assign bus.out_rem   = '0;
`endif
endmodule

// File: tb/tb_const_div_pipe.sv
// Self-checking bench for const_div_pipe (WIDTH=8, DIVISOR=3, FRAC=10) plus a
// DIVISOR=1 instance. Expected values come from integer arithmetic on the
// dividend; the macro CONST_DIV_PIPE_EXACT_EN selects exact expectations.
module tb_const_div_pipe;
  localparam int WIDTH = 8;
  localparam int DIV   = 3;
  localparam int FRAC  = 10;
`ifdef CONST_DIV_PIPE_EXACT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  const_div_pipe_if #(.WIDTH(WIDTH)) bus  ();
  const_div_pipe_if #(.WIDTH(WIDTH)) bus1 ();

  const_div_pipe #(.WIDTH(WIDTH), .DIVISOR(DIV), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  const_div_pipe #(.WIDTH(WIDTH), .DIVISOR(1), .FRAC(FRAC)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Reference: exact mode is truncating division with a dividend-signed
  // remainder; approx mode is the floored product with the ceiling reciprocal.
  function automatic int model_q(int x, int d);
    int recip;
    recip = ((1 << FRAC) + d - 1) / d;
`ifdef CONST_DIV_PIPE_EXACT_EN
    return x / d;
`else
    return (x * recip) >>> FRAC;
`endif
  endfunction

  function automatic int model_r(int x, int d);
`ifdef CONST_DIV_PIPE_EXACT_EN
    return x % d;
`else
    return 0;
`endif
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready_during: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_quot !== 8'sd0 || bus.out_rem !== 8'sd0
        || bus.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b quot=%0d rem=%0d in_ready=%b valid1=%b want 0 0 0 1 0",
               bus.out_valid, bus.out_quot, bus.out_rem, bus.in_ready, bus1.out_valid);
    end
    @(posedge clk); #1;
  endtask

  // Single item, then wait for it; checks latency and value.
  task automatic single(input string name, input int x, input int eq, input int er);
    int  lat;
    bit  found;
    lat = 0; found = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'(x);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      lat++;
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || lat != LAT) begin
      failures++; $display("FAIL %s_latency: got %0d (found=%0b) want %0d", name, lat, found, LAT);
    end
    checks++;
    if (bus.out_quot !== 8'(eq) || bus.out_rem !== 8'(er)) begin
      failures++;
      $display("FAIL %s_value: in=%0d got q=%0d r=%0d want q=%0d r=%0d",
               name, x, bus.out_quot, bus.out_rem, eq, er);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int xs [5] = '{9, -9, -1, 127, -128};
`ifdef CONST_DIV_PIPE_EXACT_EN
    int qs [5] = '{3, -3, 0, 42, -42};
    int rs [5] = '{0, 0, -1, 1, -2};
`else
    int qs [5] = '{3, -4, -1, 42, -43};
    int rs [5] = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) single($sformatf("directed%0d", i), xs[i], qs[i], rs[i]);
  endtask

  // Streams n items through with either the 1,0,0,1 ready pattern on values
  // 1..n, or random data, random bubbles and random backpressure.
  task automatic test_stream(input string name, input bit rnd, input int n);
    int exp_q[$];
    int exp_r[$];
    int exp_x[$];
    int sent, got, cyc, val, ex_q, ex_r, ex_x, err;
    bit stall_now, prev_stall;
    bit [3:0] pat;
    logic signed [7:0] prev_q, prev_r;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_q = '0; prev_r = '0;
    pat = 4'b1001;
    val = rnd ? rand_val() : 1;
    while (got < n && cyc < 40 * n + 100) begin
      bus.in_valid  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_data   = 8'(val);
      bus.out_ready = rnd ? ($urandom_range(0, 9) < 7) : pat[cyc % 4];
      @(negedge clk);
      stall_now = (bus.out_valid === 1'b1) && !bus.out_ready;
      checks++;
      if (bus.in_ready !== !stall_now) begin
        failures++;
        $display("FAIL %s_in_ready: cyc=%0d got %b want %b", name, cyc, bus.in_ready, !stall_now);
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_quot !== prev_q || bus.out_rem !== prev_r) begin
          failures++;
          $display("FAIL %s_hold: cyc=%0d got v=%b q=%0d r=%0d want v=1 q=%0d r=%0d",
                   name, cyc, bus.out_valid, bus.out_quot, bus.out_rem, prev_q, prev_r);
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back(model_q(val, DIV));
        exp_r.push_back(model_r(val, DIV));
        exp_x.push_back(val);
        sent++;
        val = rnd ? rand_val() : sent + 1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL %s_spurious: got q=%0d want no output", name, bus.out_quot);
        end else begin
          ex_q = exp_q.pop_front(); ex_r = exp_r.pop_front(); ex_x = exp_x.pop_front();
          if (bus.out_quot !== 8'(ex_q) || bus.out_rem !== 8'(ex_r)) begin
            failures++;
            $display("FAIL %s_result: in=%0d got q=%0d r=%0d want q=%0d r=%0d",
                     name, ex_x, bus.out_quot, bus.out_rem, ex_q, ex_r);
          end
          checks++;
          err = int'(bus.out_quot) - ex_x / DIV;
          if (err > 1 || err < -1) begin
            failures++;
            $display("FAIL %s_error_bound: in=%0d got q=%0d want within 1 of %0d",
                     name, ex_x, bus.out_quot, ex_x / DIV);
          end
        end
        got++;
      end
      prev_stall = stall_now;
      prev_q = bus.out_quot;
      prev_r = bus.out_rem;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != n || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_count: got %0d results (%0d pending) want %0d", name, got, exp_q.size(), n);
    end
  endtask

  // With ready held high, consecutive inputs must come out on consecutive cycles.
  task automatic test_back_to_back();
    int first, last, got, n;
    int xs[$];
    n = 10; got = 0; first = -1; last = -1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < n + LAT + 6; cyc++) begin
      bus.in_valid = (cyc < n);
      if (cyc < n) begin
        xs.push_back(rand_val());
        bus.in_data = 8'(xs[cyc]);
      end
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (got >= n || bus.out_quot !== 8'(model_q(xs[got], DIV))) begin
          failures++;
          $display("FAIL b2b_result%0d: got q=%0d want %0d", got, bus.out_quot,
                   (got < n) ? model_q(xs[got], DIV) : 0);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != n || first != LAT || last != LAT + n - 1) begin
      failures++;
      $display("FAIL b2b_timing: got %0d outputs cycles %0d..%0d want %0d outputs cycles %0d..%0d",
               got, first, last, n, LAT, LAT + n - 1);
    end
  endtask

  // Reset with three items in flight discards them; a fresh item still works.
  task automatic test_reset_flight();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(30 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_quot !== 8'sd0 || bus.out_rem !== 8'sd0) begin
      failures++;
      $display("FAIL flight_reset: got v=%b q=%0d r=%0d want 0 0 0",
               bus.out_valid, bus.out_quot, bus.out_rem);
    end
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flight_stale%0d: got v=%b in_ready=%b want 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    single("after_reset", 6, 2, 0);
  endtask

  // DIVISOR=1 must pass the dividend straight through, including the extremes.
  task automatic test_div1();
    int  x;
    bit  found;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: x = -128;
        1: x = 127;
        2: x = -1;
        3: x = 0;
        default: x = rand_val();
      endcase
      bus1.in_valid = 1'b1;
      bus1.in_data  = 8'(x);
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        if (bus1.out_valid === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found || bus1.out_quot !== 8'(x) || bus1.out_rem !== 8'sd0) begin
        failures++;
        $display("FAIL div1_%0d: found=%0b got q=%0d r=%0d want q=%0d r=0",
                 k, found, bus1.out_quot, bus1.out_rem, x);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream("stall_stream", 1'b0, 20);
    test_back_to_back();
    test_stream("random", 1'b1, 400);
    test_reset_flight();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
